// File: rtl/clk_rst_seq.sv
// Reference-clock power sequencer: programs PLL dividers, waits for lock,
// then walks domain clock enables and resets up/down in a fixed spaced order.
module clk_rst_seq #(
  parameter int CNT_W            = 16,
  parameter int STEP_GAP_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000
) (
  input  logic        ref_clk_i,
  input  logic        glob_arst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [3:0]  cfg_ref_div_e_core_i,
  input  logic [3:0]  cfg_ref_div_p_core_i,
  input  logic [3:0]  cfg_ref_div_sl_i,
  input  logic [11:0] cfg_fb_div_e_core_i,
  input  logic [11:0] cfg_fb_div_p_core_i,
  input  logic [11:0] cfg_fb_div_sl_i,
  input  logic        pll_locked_e_core_i,
  input  logic        pll_locked_p_core_i,
  input  logic        pll_locked_sl_i,
  output logic [3:0]  pll_ref_div_e_core_o,
  output logic [3:0]  pll_ref_div_p_core_o,
  output logic [3:0]  pll_ref_div_sl_o,
  output logic [11:0] pll_fb_div_e_core_o,
  output logic [11:0] pll_fb_div_p_core_o,
  output logic [11:0] pll_fb_div_sl_o,
  output logic        clk_en_cl_o,
  output logic        clk_en_sl_o,
  output logic        clk_en_pl_o,
  output logic        clk_en_e_core_o,
  output logic        clk_en_p_core_o,
  output logic        rst_cl_no,
  output logic        rst_sl_no,
  output logic        rst_pl_no,
  output logic        rst_e_core_no,
  output logic        rst_p_core_no,
  output logic        busy_o,
  output logic        ready_o,
  output logic        err_cfg_o,
  output logic        err_timeout_o,
  output logic        err_lock_lost_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PROG   = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] SEQ_UP = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] SEQ_DN = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(STEP_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(LOCK_TIMEOUT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        en_q, en_d, rn_q, rn_d;
  logic [4:0]        en_up, rn_up, en_dn, rn_dn;
  logic              up_do, dn_do;
  logic [2:0][3:0]   ref_q, ref_d, cfg_ref;
  logic [2:0][11:0]  fb_q, fb_d, cfg_fb;
  logic [2:0]        err_q, err_d;
  logic [2:0]        sync1, sync2;
  logic              locked_all, cfg_ok;
  logic              busy_q, ready_q;

  assign cfg_ref = {cfg_ref_div_sl_i, cfg_ref_div_p_core_i, cfg_ref_div_e_core_i};
  assign cfg_fb  = {cfg_fb_div_sl_i, cfg_fb_div_p_core_i, cfg_fb_div_e_core_i};
  assign locked_all = &sync2;

  always_comb begin
    cfg_ok = 1'b1;
    for (int i = 0; i < 3; i++)
      if (cfg_ref[i] == '0 || cfg_fb[i] == '0) cfg_ok = 1'b0;
  end

  // Next pending step: up enables lowest domain first, down clears highest.
  always_comb begin
    en_up = en_q;
    rn_up = rn_q;
    up_do = 1'b0;
    for (int i = 0; i < 5; i++)
      if (!up_do && !en_q[i]) begin en_up[i] = 1'b1; up_do = 1'b1; end
    for (int i = 0; i < 5; i++)
      if (!up_do && !rn_q[i]) begin rn_up[i] = 1'b1; up_do = 1'b1; end
    en_dn = en_q;
    rn_dn = rn_q;
    dn_do = 1'b0;
    for (int i = 4; i >= 0; i--)
      if (!dn_do && rn_q[i]) begin rn_dn[i] = 1'b0; dn_do = 1'b1; end
    for (int i = 4; i >= 0; i--)
      if (!dn_do && en_q[i]) begin en_dn[i] = 1'b0; dn_do = 1'b1; end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rn_d    = rn_q;
    ref_d   = ref_q;
    fb_d    = fb_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if (cfg_ok) begin
            ref_d   = cfg_ref;
            fb_d    = cfg_fb;
            cnt_d   = '0;
            state_d = PROG;
          end else begin
            err_d[0] = 1'b1;
            state_d  = ERR;
          end
        end
      end
      PROG: begin
        if (stop_i) state_d = IDLE;
        else if (cnt_q == GAP_M1) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else cnt_d = cnt_q + 1'b1;
      end
      WAIT: begin
        if (stop_i) state_d = IDLE;
        else if (locked_all) begin
          en_d    = en_up;
          rn_d    = rn_up;
          cnt_d   = '0;
          state_d = SEQ_UP;
        end else if (cnt_q == TO_M1) begin
          err_d[1] = 1'b1;
          state_d  = ERR;
        end else cnt_d = cnt_q + 1'b1;
      end
      SEQ_UP, RUN, SEQ_DN: begin
        if (!locked_all) begin
          en_d     = '0;
          rn_d     = '0;
          err_d[2] = 1'b1;
          state_d  = ERR;
        end else if (stop_i && state_q != SEQ_DN) begin
          cnt_d = '0;
          if (dn_do) begin
            en_d    = en_dn;
            rn_d    = rn_dn;
            state_d = SEQ_DN;
          end else state_d = IDLE;
        end else if (state_q != RUN) begin
          if (cnt_q == GAP_M1) begin
            cnt_d = '0;
            if (state_q == SEQ_UP) begin
              if (up_do) begin
                en_d = en_up;
                rn_d = rn_up;
              end else state_d = RUN;
            end else begin
              if (dn_do) begin
                en_d = en_dn;
                rn_d = rn_dn;
              end else state_d = IDLE;
            end
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        if (stop_i) begin
          err_d   = '0;
          state_d = IDLE;
        end else if (start_i) begin
          err_d = '0;
          if (cfg_ok) begin
            ref_d   = cfg_ref;
            fb_d    = cfg_fb;
            cnt_d   = '0;
            state_d = PROG;
          end else err_d[0] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
    if (!glob_arst_ni) begin
      sync1   <= '0;
      sync2   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
      rn_q    <= '0;
      ref_q   <= '0;
      fb_q    <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      sync1   <= {pll_locked_sl_i, pll_locked_p_core_i, pll_locked_e_core_i};
      sync2   <= sync1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rn_q    <= rn_d;
      ref_q   <= ref_d;
      fb_q    <= fb_d;
      err_q   <= err_d;
      busy_q  <= (state_d == PROG) || (state_d == WAIT) ||
                 (state_d == SEQ_UP) || (state_d == SEQ_DN);
      ready_q <= (state_d == RUN);
    end
  end

  assign pll_ref_div_e_core_o = ref_q[0];
  assign pll_ref_div_p_core_o = ref_q[1];
  assign pll_ref_div_sl_o     = ref_q[2];
  assign pll_fb_div_e_core_o  = fb_q[0];
  assign pll_fb_div_p_core_o  = fb_q[1];
  assign pll_fb_div_sl_o      = fb_q[2];
  assign clk_en_cl_o     = en_q[0];
  assign clk_en_sl_o     = en_q[1];
  assign clk_en_pl_o     = en_q[2];
  assign clk_en_e_core_o = en_q[3];
  assign clk_en_p_core_o = en_q[4];
  assign rst_cl_no       = rn_q[0];
  assign rst_sl_no       = rn_q[1];
  assign rst_pl_no       = rn_q[2];
  assign rst_e_core_no   = rn_q[3];
  assign rst_p_core_no   = rn_q[4];
  assign busy_o          = busy_q;
  assign ready_o         = ready_q;
  assign err_cfg_o       = err_q[0];
  assign err_timeout_o   = err_q[1];
  assign err_lock_lost_o = err_q[2];

endmodule
